// File: rtl/mc10162_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mc10162_phase_sequencer_if
// Brief    : Control and decoder-drive bundle for the mc10162 phase sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mc10162_phase_sequencer_if;
  // Sequence control inputs
  logic       start;
  logic       step_mode;
  logic       step;
  logic       abort;
  logic       inhibit;
  // Decoder drive and status outputs
  logic       sel4;
  logic       sel2;
  logic       sel1;
  logic       nen1;
  logic       nen2;
  logic [2:0] phase;
  logic       busy;
  logic       done;

  // Controller side: issues requests, observes the decoder drive
  modport master (
    output start, step_mode, step, abort, inhibit,
    input  sel4, sel2, sel1, nen1, nen2, phase, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, step_mode, step, abort, inhibit,
    output sel4, sel2, sel1, nen1, nen2, phase, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mc10162_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mc10162_phase_sequencer
// Brief    : Steps the select/enable inputs of a downstream mc10162 3-to-8
//            decoder through NPHASES phases of DWELL clocks each, with
//            free-run / single-step modes, abort and strobe inhibit.
// Revision : 1.0 - initial release
// ============================================================================
module mc10162_phase_sequencer #(
  parameter int NPHASES = 8,  // phases per sequence, 1..8
  parameter int DWELL   = 1   // clocks per phase, 1..16
) (
  input  wire logic                clk,
  input  wire logic                reset,
  mc10162_phase_sequencer_if.slave bus
);

  localparam logic [2:0] C_LAST_PHASE  = 3'(NPHASES - 1);
  localparam logic [3:0] C_DWELL_RELOAD = 4'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       nen1_q,  nen1_d;
  logic       nen2_q,  nen2_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  // Next-state logic; outputs are decoded from the next state so they can be
  // registered alongside it with no input-to-output combinational path.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    nen1_d  = 1'b1;
    nen2_d  = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Abort outranks start, so a coincident start is simply dropped
        if (!bus.abort && bus.start) begin
          state_d = S_ACTIVE;
          phase_d = 3'd0;
          cnt_d   = C_DWELL_RELOAD;
        end
      end
      S_ACTIVE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          phase_d = 3'd0;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (phase_q == C_LAST_PHASE) begin
          // Phase is kept through DONE so select never moves with the
          // enable transition
          state_d = S_DONE;
        end else if (bus.step_mode) begin
          state_d = S_HOLD;
        end else begin
          phase_d = phase_q + 3'd1;
          cnt_d   = C_DWELL_RELOAD;
        end
      end
      S_HOLD: begin
        // Clearing step_mode here does not resume; only step does
        if (bus.abort) begin
          state_d = S_IDLE;
          phase_d = 3'd0;
          cnt_d   = 4'd0;
        end else if (bus.step) begin
          state_d = S_ACTIVE;
          phase_d = phase_q + 3'd1;
          cnt_d   = C_DWELL_RELOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = 3'd0;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 3'd0;
        cnt_d   = 4'd0;
      end
    endcase

    case (state_d)
      S_ACTIVE: begin
        nen1_d = 1'b0;
        nen2_d = bus.inhibit;
        busy_d = 1'b1;
      end
      S_HOLD: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 3'd0;
      cnt_q   <= 4'd0;
      nen1_q  <= 1'b1;
      nen2_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      nen1_q  <= nen1_d;
      nen2_q  <= nen2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.phase = phase_q;
  assign bus.sel4  = phase_q[2];
  assign bus.sel2  = phase_q[1];
  assign bus.sel1  = phase_q[0];
  assign bus.nen1  = nen1_q;
  assign bus.nen2  = nen2_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mc10162_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc10162_phase_sequencer
// Brief    : Self-checking bench for mc10162_phase_sequencer using three
//            parameterisations (8x1, 5x3, 8x2) and an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc10162_phase_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc10162_phase_sequencer_if bus_a ();
  mc10162_phase_sequencer_if bus_b ();
  mc10162_phase_sequencer_if bus_c ();

  mc10162_phase_sequencer #(.NPHASES(8), .DWELL(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  mc10162_phase_sequencer #(.NPHASES(5), .DWELL(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));
  mc10162_phase_sequencer #(.NPHASES(8), .DWELL(2)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.slave));

  // Observation vector: {phase, sel4, sel2, sel1, nen1, nen2, busy, done}
  logic [9:0] obs_a, obs_b, obs_c;
  assign obs_a = {bus_a.phase, bus_a.sel4, bus_a.sel2, bus_a.sel1,
                  bus_a.nen1, bus_a.nen2, bus_a.busy, bus_a.done};
  assign obs_b = {bus_b.phase, bus_b.sel4, bus_b.sel2, bus_b.sel1,
                  bus_b.nen1, bus_b.nen2, bus_b.busy, bus_b.done};
  assign obs_c = {bus_c.phase, bus_c.sel4, bus_c.sel2, bus_c.sel1,
                  bus_c.nen1, bus_c.nen2, bus_c.busy, bus_c.done};

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];

  function automatic logic [9:0] ev(input logic [2:0] ph, input logic n1,
                                    input logic n2, input logic b, input logic d);
    return {ph, ph, n1, n2, b, d};
  endfunction

  localparam logic [9:0] C_IDLE = {3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic logic [9:0] obs_of(input int which);
    case (which)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  // s = {start, step_mode, step, abort, inhibit}
  task automatic apply(input int which, input logic [4:0] s);
    case (which)
      0: begin
        bus_a.start = s[4]; bus_a.step_mode = s[3]; bus_a.step = s[2];
        bus_a.abort = s[1]; bus_a.inhibit = s[0];
      end
      1: begin
        bus_b.start = s[4]; bus_b.step_mode = s[3]; bus_b.step = s[2];
        bus_b.abort = s[1]; bus_b.inhibit = s[0];
      end
      default: begin
        bus_c.start = s[4]; bus_c.step_mode = s[3]; bus_c.step = s[2];
        bus_c.abort = s[1]; bus_c.inhibit = s[0];
      end
    endcase
  endtask

  task automatic test_reset();
    logic [9:0] e, got;
    reset = 1'b1;
    apply(0, 5'b0); apply(1, 5'b0); apply(2, 5'b0);
    #12;
    for (int w = 0; w < 3; w++) begin
      got = obs_of(w);
      n_checks++;
      if (got !== C_IDLE) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %b expected %b", w, got, C_IDLE);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    // Run dut_a up to phase 3
    for (int k = 0; k < 4; k++) begin
      apply(0, {(k == 0), 4'b0});
      exp_q.push_back(ev(3'(k), 1'b0, 1'b0, 1'b1, 1'b0));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL reset_pre[%0d]: got %b expected %b", k, obs_a, e);
      end
    end
    // Assert reset between clock edges: outputs must clear without an edge
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_a !== C_IDLE) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs_a, C_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back(C_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %b expected %b", k, obs_a, e);
      end
    end
  endtask

  task automatic test_free_run();
    logic [4:0] stim_q[$];
    logic [9:0] e;
    for (int k = 0; k < 8; k++) begin
      stim_q.push_back({(k == 0), 4'b0});
      exp_q.push_back(ev(3'(k), 1'b0, 1'b0, 1'b1, 1'b0));
    end
    stim_q.push_back(5'b0); exp_q.push_back(ev(3'd7, 1'b1, 1'b1, 1'b0, 1'b1));
    stim_q.push_back(5'b0); exp_q.push_back(C_IDLE);
    for (int k = 0; k < stim_q.size(); k++) begin
      apply(0, stim_q[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL free_run[%0d]: got %b expected %b", k, obs_a, e);
      end
    end
  endtask

  task automatic test_dwell();
    logic [4:0] stim_q[$];
    logic [9:0] e;
    for (int k = 0; k < 15; k++) begin
      stim_q.push_back({(k == 0), 4'b0});
      exp_q.push_back(ev(3'(k / 3), 1'b0, 1'b0, 1'b1, 1'b0));
    end
    stim_q.push_back(5'b0); exp_q.push_back(ev(3'd4, 1'b1, 1'b1, 1'b0, 1'b1));
    stim_q.push_back(5'b0); exp_q.push_back(C_IDLE);
    for (int k = 0; k < stim_q.size(); k++) begin
      apply(1, stim_q[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_b !== e) begin
        n_fail++;
        $display("FAIL dwell[%0d]: got %b expected %b", k, obs_b, e);
      end
    end
  endtask

  task automatic test_step_mode();
    logic [4:0] stim_q[$];
    logic [9:0] e;
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 2; a++) begin
        stim_q.push_back({(p == 0 && a == 0), 1'b1, (p > 0 && a == 0), 2'b0});
        exp_q.push_back(ev(3'(p), 1'b0, 1'b0, 1'b1, 1'b0));
      end
      if (p < 7) begin
        for (int h = 0; h < 4; h++) begin
          // Dropping step_mode during phase 2's hold must not resume
          stim_q.push_back({1'b0, !(p == 2 && h >= 1), 3'b0});
          exp_q.push_back(ev(3'(p), 1'b1, 1'b1, 1'b1, 1'b0));
        end
      end
    end
    stim_q.push_back(5'b01000); exp_q.push_back(ev(3'd7, 1'b1, 1'b1, 1'b0, 1'b1));
    stim_q.push_back(5'b00000); exp_q.push_back(C_IDLE);
    for (int k = 0; k < stim_q.size(); k++) begin
      apply(2, stim_q[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_c !== e) begin
        n_fail++;
        $display("FAIL step_mode[%0d]: got %b expected %b", k, obs_c, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [4:0] stim_q[$];
    logic [9:0] e;
    // Abort with step while in HOLD (dut_c)
    stim_q.push_back(5'b11000); exp_q.push_back(ev(3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    stim_q.push_back(5'b01000); exp_q.push_back(ev(3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    stim_q.push_back(5'b01000); exp_q.push_back(ev(3'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    stim_q.push_back(5'b01110); exp_q.push_back(C_IDLE);
    stim_q.push_back(5'b00000); exp_q.push_back(C_IDLE);
    for (int k = 0; k < stim_q.size(); k++) begin
      apply(2, stim_q[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_c !== e) begin
        n_fail++;
        $display("FAIL abort_hold[%0d]: got %b expected %b", k, obs_c, e);
      end
    end
    stim_q.delete();
    // Abort with step at phase 2 of a free run, then immediate restart (dut_a)
    for (int k = 0; k < 3; k++) begin
      stim_q.push_back({(k == 0), 4'b0});
      exp_q.push_back(ev(3'(k), 1'b0, 1'b0, 1'b1, 1'b0));
    end
    stim_q.push_back(5'b00110); exp_q.push_back(C_IDLE);
    for (int k = 0; k < 8; k++) begin
      stim_q.push_back({(k == 0), 4'b0});
      exp_q.push_back(ev(3'(k), 1'b0, 1'b0, 1'b1, 1'b0));
    end
    stim_q.push_back(5'b00000); exp_q.push_back(ev(3'd7, 1'b1, 1'b1, 1'b0, 1'b1));
    stim_q.push_back(5'b00000); exp_q.push_back(C_IDLE);
    // Abort outranks start in IDLE
    stim_q.push_back(5'b10010); exp_q.push_back(C_IDLE);
    stim_q.push_back(5'b00000); exp_q.push_back(C_IDLE);
    for (int k = 0; k < stim_q.size(); k++) begin
      apply(0, stim_q[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL abort_run[%0d]: got %b expected %b", k, obs_a, e);
      end
    end
  endtask

  task automatic test_inhibit();
    logic [4:0] stim_q[$];
    logic [9:0] e;
    for (int k = 0; k < 8; k++) begin
      stim_q.push_back({(k == 0), 3'b0, (k == 3 || k == 4)});
      exp_q.push_back(ev(3'(k), 1'b0, (k == 3 || k == 4), 1'b1, 1'b0));
    end
    stim_q.push_back(5'b00001); exp_q.push_back(ev(3'd7, 1'b1, 1'b1, 1'b0, 1'b1));
    stim_q.push_back(5'b00001); exp_q.push_back(C_IDLE);
    stim_q.push_back(5'b00001); exp_q.push_back(C_IDLE);
    stim_q.push_back(5'b00000); exp_q.push_back(C_IDLE);
    for (int k = 0; k < stim_q.size(); k++) begin
      apply(0, stim_q[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL inhibit[%0d]: got %b expected %b", k, obs_a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] stim_q[$];
    logic [9:0] e;
    // start held high: restart one clock after DONE, ignored in DONE
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        stim_q.push_back(5'b10000);
        exp_q.push_back(ev(3'(k), 1'b0, 1'b0, 1'b1, 1'b0));
      end
      stim_q.push_back({(r == 0), 4'b0});
      exp_q.push_back(ev(3'd7, 1'b1, 1'b1, 1'b0, 1'b1));
      stim_q.push_back({(r == 0), 4'b0});
      exp_q.push_back(C_IDLE);
    end
    for (int k = 0; k < stim_q.size(); k++) begin
      apply(0, stim_q[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", k, obs_a, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_free_run();
    test_dwell();
    test_step_mode();
    test_abort();
    test_inhibit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
